mem_stage_lsu: RTL and testbench

Parametrised successor to the MEM pipeline stage. Registers the EX→MEM payload under the stall/flush protocol and tracks the outstanding data-SRAM load response, which may arrive 0..N cycles late. Extracts and extends byte, halfword, word (and doubleword) loads, detects misalignment, and drives the MEM→WB and MEM→RF forwarding buses. It sits between EX and WB and raises a stall request while a load response is pending.

---
 rtl/mem_stage_lsu.sv | 172 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// MEM pipeline stage with a load-store unit front end. Holds the EX->MEM
// payload under the stall/flush protocol. Tracks one outstanding data-SRAM
// load response, which may arrive zero or more cycles after capture. Extracts
// and extends the loaded lane and drives the MEM->WB and MEM->RF forwarding
// buses.
//
// Parameters: DATA_W (32 or 64), PC_W, RF_AW, STALL_W (bit 3 = MEM, bit 4 = WB)
// Ports:
//   clk, rst (async, active-low), flush (sync clear), stall[STALL_W]
//   ex_valid/ex_pc/ex_rf_we/ex_rf_waddr/ex_result/ex_is_load/ex_ld_op : EX payload
//   data_sram_rvalid/data_sram_rdata : load response (aligned memory word)
//   stallreq_mem : load response still outstanding
//   addr_err     : misaligned or illegal load sitting in the stage
//   wb_*         : MEM->WB bus
//   fwd_*        : MEM->RF forwarding bus
module mem_stage_lsu #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int RF_AW   = 5,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic               ex_valid,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic               ex_rf_we,
  input  logic [RF_AW-1:0]   ex_rf_waddr,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic               ex_is_load,
  input  logic [2:0]         ex_ld_op,
  input  logic               data_sram_rvalid,
  input  logic [DATA_W-1:0]  data_sram_rdata,
  output logic               stallreq_mem,
  output logic               addr_err,
  output logic               wb_valid,
  output logic [PC_W-1:0]    wb_pc,
  output logic               wb_rf_we,
  output logic [RF_AW-1:0]   wb_rf_waddr,
  output logic [DATA_W-1:0]  wb_rf_wdata,
  output logic               fwd_rf_we,
  output logic [RF_AW-1:0]   fwd_rf_waddr,
  output logic [DATA_W-1:0]  fwd_rf_wdata
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LD  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;
  localparam logic [2:0] OP_LWU = 3'd6;

  localparam logic [STALL_W-1:0] MEM_WB_MASK = (STALL_W'(1) << 3) | (STALL_W'(1) << 4);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GOT} ld_state_e;

  ld_state_e          state_q;
  logic               valid_q;
  logic [PC_W-1:0]    pc_q;
  logic               rf_we_q;
  logic [RF_AW-1:0]   waddr_q;
  logic [DATA_W-1:0]  result_q;
  logic               is_load_q;
  logic [2:0]         ld_op_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [OFF_W-1:0]   off;
  logic [DATA_W-1:0]  raw;
  logic [31:0]        lane;
  logic [DATA_W-1:0]  extracted;
  logic               load_starts;

  // Only the MEM and WB bits of the stall vector matter to this stage.
  logic unused_stall;
  assign unused_stall = ^(stall & ~MEM_WB_MASK);

  // Alignment/legality rule shared by the EX side (to decide whether to wait
  // for a response) and by the stage itself (to raise addr_err).
  function automatic logic misaligned(input logic [2:0] op, input logic [OFF_W-1:0] o);
    logic bad;
    case (op)
      OP_LH, OP_LHU: bad = o[0];
      OP_LW:         bad = (o[1:0] != 2'b00);
      OP_LWU:        bad = (DATA_W == 32) || (o[1:0] != 2'b00);
      OP_LD:         bad = (DATA_W == 32) || (o != '0);
      3'd7:          bad = 1'b1;
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

  // A faulting load never issues a memory wait, so it cannot stall the pipe.
  assign load_starts = ex_valid && ex_is_load && !misaligned(ex_ld_op, ex_result[OFF_W-1:0]);

  // Stage register and load FSM. Flush and the MEM-stalled/WB-free case both
  // empty the stage, abandoning any pending response. A held entry that sees
  // its response latches it so later changes on the SRAM bus do not matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rf_we_q   <= 1'b0;
      waddr_q   <= '0;
      result_q  <= '0;
      is_load_q <= 1'b0;
      ld_op_q   <= '0;
      rdata_q   <= '0;
    end else if (flush || (stall[3] && !stall[4])) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rf_we_q   <= 1'b0;
      waddr_q   <= '0;
      result_q  <= '0;
      is_load_q <= 1'b0;
      ld_op_q   <= '0;
      rdata_q   <= '0;
    end else if (!stall[3]) begin
      state_q   <= load_starts ? ST_WAIT : ST_IDLE;
      valid_q   <= ex_valid;
      pc_q      <= ex_pc;
      rf_we_q   <= ex_rf_we;
      waddr_q   <= ex_rf_waddr;
      result_q  <= ex_result;
      is_load_q <= ex_is_load;
      ld_op_q   <= ex_ld_op;
      rdata_q   <= '0;
    end else if (state_q == ST_WAIT && data_sram_rvalid) begin
      state_q <= ST_GOT;
      rdata_q <= data_sram_rdata;
    end
  end

  assign off  = result_q[OFF_W-1:0];
  assign raw  = (state_q == ST_GOT) ? rdata_q : data_sram_rdata;
  assign lane = 32'(raw >> {off, 3'b000});

  // Lane extraction; LD (and LWU on a 32-bit datapath) use the whole word.
  always_comb begin
    extracted = raw;
    case (ld_op_q)
      OP_LB:   extracted = DATA_W'($signed(lane[7:0]));
      OP_LH:   extracted = DATA_W'($signed(lane[15:0]));
      OP_LW:   extracted = DATA_W'($signed(lane));
      OP_LBU:  extracted = DATA_W'(lane[7:0]);
      OP_LHU:  extracted = DATA_W'(lane[15:0]);
      OP_LWU:  extracted = (DATA_W == 32) ? raw : DATA_W'(lane);
      default: extracted = raw;
    endcase
  end

  assign stallreq_mem = (state_q == ST_WAIT) && !data_sram_rvalid;
  assign addr_err     = valid_q && is_load_q && misaligned(ld_op_q, off);

  assign wb_valid    = valid_q && !stallreq_mem;
  assign wb_pc       = pc_q;
  assign wb_rf_we    = valid_q && rf_we_q && !addr_err;
  assign wb_rf_waddr = waddr_q;
  assign wb_rf_wdata = is_load_q ? extracted : result_q;

  // Forwarding must not expose a load value that has not arrived yet.
  assign fwd_rf_we    = wb_rf_we && !stallreq_mem;
  assign fwd_rf_waddr = waddr_q;
  assign fwd_rf_wdata = wb_rf_wdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
// Drives a 32-bit and a 64-bit mem_stage_lsu from the same stimulus stream.
// Each issued instruction pushes its expected retirement record into a
// per-instance queue; a monitor per instance pops and compares whenever the
// stage hands a valid entry to WB (stage not held, no flush).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [63:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_ld_op;
  logic        rvalid;
  logic [63:0] rdata;

  logic        sreq32, aerr32, wbv32, wbwe32, fwe32;
  logic [31:0] wbpc32, wbwd32, fwd32;
  logic [4:0]  wbwa32, fwa32;
  logic        sreq64, aerr64, wbv64, wbwe64, fwe64;
  logic [31:0] wbpc64;
  logic [63:0] wbwd64, fwd64;
  logic [4:0]  wbwa64, fwa64;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] result;
    logic        isLoad;
    logic [2:0]  op;
    logic [63:0] rdata;
    int          lat;
    int          hold;
    int          kill;   // 0 none, 1 flush, 2 bubble, 3 async reset
  } InstrT;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        err;
    logic        chkData;
  } ExpT;

  InstrT prog[$];
  ExpT   q32[$];
  ExpT   q64[$];

  always #5 clk = ~clk;

  mem_stage_lsu #(.DATA_W(32), .PC_W(32), .RF_AW(5), .STALL_W(6)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_result(ex_result[31:0]), .ex_is_load(ex_is_load), .ex_ld_op(ex_ld_op),
    .data_sram_rvalid(rvalid), .data_sram_rdata(rdata[31:0]),
    .stallreq_mem(sreq32), .addr_err(aerr32),
    .wb_valid(wbv32), .wb_pc(wbpc32), .wb_rf_we(wbwe32), .wb_rf_waddr(wbwa32), .wb_rf_wdata(wbwd32),
    .fwd_rf_we(fwe32), .fwd_rf_waddr(fwa32), .fwd_rf_wdata(fwd32)
  );

  mem_stage_lsu #(.DATA_W(64), .PC_W(32), .RF_AW(5), .STALL_W(6)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_result(ex_result), .ex_is_load(ex_is_load), .ex_ld_op(ex_ld_op),
    .data_sram_rvalid(rvalid), .data_sram_rdata(rdata),
    .stallreq_mem(sreq64), .addr_err(aerr64),
    .wb_valid(wbv64), .wb_pc(wbpc64), .wb_rf_we(wbwe64), .wb_rf_waddr(wbwa64), .wb_rf_wdata(wbwd64),
    .fwd_rf_we(fwe64), .fwd_rf_waddr(fwa64), .fwd_rf_wdata(fwd64)
  );

  // Reference model: legality of a load at a given address on a dw-bit datapath.
  function automatic logic modelErr(input int dw, input logic [2:0] op, input logic [63:0] addr);
    int off;
    off = int'(addr[2:0]) % (dw / 8);
    case (op)
      3'd1, 3'd5: return (off % 2) != 0;
      3'd2:       return (off % 4) != 0;
      3'd6:       return (dw == 32) || ((off % 4) != 0);
      3'd3:       return (dw == 32) || (off != 0);
      3'd7:       return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic longint unsigned signExt(input longint unsigned v, input int bits);
    longint unsigned one;
    one = 1;
    return (v >= (one << (bits - 1))) ? v - (one << bits) : v;
  endfunction

  // Reference model: value written back for a legal load.
  function automatic logic [63:0] modelData(input int dw, input logic [2:0] op,
                                            input logic [63:0] addr, input logic [63:0] rd);
    longint unsigned one, mask, word, lane, res;
    int off;
    one  = 1;
    mask = (dw == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    word = rd & mask;
    off  = int'(addr[2:0]) % (dw / 8);
    lane = word >> (8 * off);
    case (op)
      3'd0:    res = signExt(lane % 256, 8);
      3'd1:    res = signExt(lane % 65536, 16);
      3'd2:    res = (dw == 32) ? word : signExt(lane % (one << 32), 32);
      3'd4:    res = lane % 256;
      3'd5:    res = lane % 65536;
      3'd6:    res = (dw == 32) ? word : lane % (one << 32);
      default: res = word;
    endcase
    return res & mask;
  endfunction

  function automatic ExpT makeExp(input int dw, input InstrT p);
    ExpT e;
    logic bad;
    logic [63:0] mask;
    mask      = (dw == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    bad       = p.isLoad && modelErr(dw, p.op, p.result);
    e.pc      = p.pc;
    e.we      = p.we && !bad;
    e.waddr   = p.waddr;
    e.err     = bad;
    e.chkData = !bad;
    e.wdata   = p.isLoad ? modelData(dw, p.op, p.result, p.rdata) : (p.result & mask);
    return e;
  endfunction

  function automatic InstrT mk(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                               input logic [63:0] res, input logic ld, input logic [2:0] op,
                               input logic [63:0] rd, input int lat, input int hold, input int kill);
    InstrT p;
    p.pc = pc; p.we = we; p.waddr = wa; p.result = res; p.isLoad = ld; p.op = op;
    p.rdata = rd; p.lat = lat; p.hold = hold; p.kill = kill;
    return p;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic InstrT genRandom();
    InstrT p;
    p = mk($urandom, 1'($urandom), 5'($urandom), rand64(), ($urandom_range(0, 9) < 7),
           3'($urandom), rand64(), 0, 0, 0);
    if (p.isLoad) begin
      p.lat  = $urandom_range(0, 3);
      p.hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      p.kill = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
    end else begin
      p.hold = $urandom_range(0, 1);
    end
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRetire(input string tag, input ExpT e, input logic [31:0] pc, input logic we,
                             input logic [4:0] wa, input logic [63:0] wd, input logic err,
                             input logic fwe, input logic [4:0] fwa, input logic [63:0] fwdat);
    checkOutput({tag, "_ctrl"}, {pc, we, wa, err}, {e.pc, e.we, e.waddr, e.err});
    if (e.chkData) begin
      checkOutput({tag, "_data"}, wd, e.wdata);
      checkOutput({tag, "_fwd"}, {fwe, fwa, fwdat}, {e.we, e.waddr, e.wdata});
    end else begin
      checkOutput({tag, "_fwd_we"}, {fwe, fwa}, {e.we, e.waddr});
    end
  endtask

  task automatic setEx(input InstrT p, input logic v);
    ex_valid    = v;
    ex_pc       = p.pc;
    ex_rf_we    = p.we;
    ex_rf_waddr = p.waddr;
    ex_result   = p.result;
    ex_is_load  = p.isLoad;
    ex_ld_op    = p.op;
  endtask

  task automatic pushExp(input InstrT p);
    if (p.kill == 0) begin
      q32.push_back(makeExp(32, p));
      q64.push_back(makeExp(64, p));
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "32"}, {sreq32, aerr32, wbv32, wbpc32, wbwe32, wbwa32, wbwd32, fwe32, fwa32, fwd32}, '0);
    checkOutput({tag, "64"}, {sreq64, aerr64, wbv64, wbpc64, wbwe64, wbwa64, wbwd64, fwe64, fwa64, fwd64}, '0);
  endtask

  // Runs one instruction's residency in MEM; on its last cycle the stage is
  // released and the next instruction (or a bubble) is presented from EX.
  task automatic applyStimulus(input InstrT cur, input InstrT nxt, input logic hasNext);
    logic w32, w64, e32, e64;
    int last;
    w32  = cur.isLoad && !modelErr(32, cur.op, cur.result);
    w64  = cur.isLoad && !modelErr(64, cur.op, cur.result);
    last = (cur.kill != 0) ? 1 : cur.lat + cur.hold;
    for (int c = 0; c <= last; c++) begin
      nextCycle();
      rst   = 1'b1;
      flush = 1'b0;
      if (c == last) begin
        stall = {1'($urandom), 2'b00, 3'($urandom)};
        setEx(nxt, hasNext);
        if (hasNext) pushExp(nxt);
      end else begin
        stall = {1'($urandom), 2'b11, 3'($urandom)};
        setEx(genRandom(), 1'($urandom));
      end
      if (cur.isLoad && cur.kill == 0) begin
        rvalid = (c == cur.lat) ? 1'b1 : ((c > cur.lat) ? 1'($urandom) : 1'b0);
        rdata  = (c == cur.lat) ? cur.rdata : rand64();
      end else if (cur.isLoad) begin
        rvalid = (c == 1);
        rdata  = rand64();
      end else begin
        rvalid = 1'($urandom);
        rdata  = rand64();
      end
      if (c == 0 && cur.kill == 1) flush = 1'b1;
      if (c == 0 && cur.kill == 2) stall = {1'($urandom), 2'b01, 3'($urandom)};
      if (c == 0 && cur.kill == 3) begin
        #1 rst = 1'b0;
        #1;
        checkOutput("async_rst_quiet", {sreq32, wbv32, sreq64, wbv64}, 4'b0000);
      end
      @(negedge clk);
      if (cur.kill == 0) begin
        e32 = w32 && (c < cur.lat);
        e64 = w64 && (c < cur.lat);
      end else begin
        e32 = w32 && (c == 0) && (cur.kill != 3);
        e64 = w64 && (c == 0) && (cur.kill != 3);
      end
      checkOutput("stallreq32", sreq32, e32);
      checkOutput("stallreq64", sreq64, e64);
      if (e32) checkOutput("fwd_we_stall32", fwe32, 1'b0);
      if (e64) checkOutput("fwd_we_stall64", fwe64, 1'b0);
    end
  endtask

  // Retirement monitors: an entry leaves MEM when the stage is not held.
  always @(negedge clk) begin
    if (rst && !flush && !stall[3] && wbv32) begin
      if (q32.size() == 0) begin
        checkOutput("wb_valid32_unexpected", wbv32, 1'b0);
      end else begin
        ExpT e;
        e = q32.pop_front();
        checkRetire("ret32", e, wbpc32, wbwe32, wbwa32, {32'b0, wbwd32}, aerr32, fwe32, fwa32, {32'b0, fwd32});
      end
    end
  end

  always @(negedge clk) begin
    if (rst && !flush && !stall[3] && wbv64) begin
      if (q64.size() == 0) begin
        checkOutput("wb_valid64_unexpected", wbv64, 1'b0);
      end else begin
        ExpT e;
        e = q64.pop_front();
        checkRetire("ret64", e, wbpc64, wbwe64, wbwa64, wbwd64, aerr64, fwe64, fwa64, fwd64);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not complete, %0d tests run", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    InstrT idle;
    rst = 1'b0; flush = 1'b0; stall = '0; rvalid = 1'b0; rdata = '0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setEx(idle, 1'b0);

    #3;
    checkQuiet("reset_during");
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkQuiet("reset_after");

    // Directed cases from the block's bring-up list, then random traffic.
    prog.push_back(mk(32'h100, 1, 5'd5, 64'h1234_5678, 0, 3'd2, 0, 0, 0, 0));
    prog.push_back(mk(32'h104, 1, 5'd6, 64'h1003, 1, 3'd0, 64'h80FF_0000, 0, 0, 0));
    prog.push_back(mk(32'h108, 1, 5'd7, 64'h1003, 1, 3'd4, 64'h80FF_0000, 0, 0, 0));
    prog.push_back(mk(32'h10C, 1, 5'd8, 64'h2002, 1, 3'd1, 64'h7FFF_0001, 3, 0, 0));
    prog.push_back(mk(32'h110, 1, 5'd9, 64'h2002, 1, 3'd1, 64'h8001_0000, 1, 2, 0));
    prog.push_back(mk(32'h114, 1, 5'd10, 64'h3002, 1, 3'd2, rand64(), 2, 0, 0));
    prog.push_back(mk(32'h118, 1, 5'd11, 64'h3000, 1, 3'd2, rand64(), 2, 0, 1));
    prog.push_back(mk(32'h11C, 1, 5'd12, 64'h4000, 1, 3'd3, 64'h8000_0000_0000_0001, 1, 0, 0));
    prog.push_back(mk(32'h120, 1, 5'd13, 64'h4004, 1, 3'd6, 64'h89AB_CDEF_0000_0000, 0, 0, 0));
    prog.push_back(mk(32'h124, 1, 5'd14, 64'h5004, 1, 3'd2, 64'h8000_0000_1234_5678, 2, 0, 0));
    prog.push_back(mk(32'h128, 1, 5'd15, 64'h6000, 1, 3'd2, rand64(), 1, 0, 2));
    prog.push_back(mk(32'h12C, 1, 5'd16, 64'h6000, 1, 3'd2, rand64(), 1, 0, 3));
    prog.push_back(mk(32'h130, 1, 5'd17, 64'hABCD_0000_5555_AAAA, 0, 3'd7, 0, 0, 1, 0));
    for (int i = 0; i < 150; i++) prog.push_back(genRandom());

    nextCycle();
    stall = '0;
    setEx(prog[0], 1'b1);
    pushExp(prog[0]);
    for (int i = 0; i < prog.size(); i++) begin
      if (i + 1 < prog.size()) applyStimulus(prog[i], prog[i + 1], 1'b1);
      else                     applyStimulus(prog[i], idle, 1'b0);
    end

    repeat (3) begin
      nextCycle();
      rst = 1'b1; flush = 1'b0; stall = '0; rvalid = 1'b0;
      setEx(idle, 1'b0);
    end
    @(negedge clk);
    checkOutput("drain32", q32.size(), 0);
    checkOutput("drain64", q64.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
